// File: rtl/mutative_types.sv
// Shared types and constants for the mutative cache slice.
//
// Contents:
//   CLA_BEAT_W     - burst beat width used by the cacheline adapter
//   CLA_BURST_LEN  - beats per cache line on the burst port
//   cla_state_t    - cacheline adapter FSM states
//   cla_line_align - clears the byte-in-line offset of an address
package mutative_types;

  localparam int CLA_BEAT_W    = 64;
  localparam int CLA_BURST_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } cla_state_t;

  // 256-bit lines are 32 bytes, so the low five address bits select a byte.
  function automatic logic [31:0] cla_line_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage

// File: rtl/mutative_cacheline_adapter.sv
// mutative_cacheline_adapter
//
// Bridges the cache's line-granular memory port (dfp_*) to a burst memory
// port (bmem_*). Writebacks are serialised into BURST_LEN beats, read
// bursts are gathered into one line, and each transaction ends with a
// single-cycle dfp_resp. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   dfp_addr/read/write  - line request from the cache (level-held)
//   dfp_wdata            - line to write back
//   dfp_rdata            - last assembled read line (held until next read)
//   dfp_resp             - one-cycle transaction-done pulse
//   bmem_addr            - line-aligned burst address
//   bmem_read            - read command (held until bmem_ready)
//   bmem_write/wdata     - write beat valid and data
//   bmem_ready           - memory accepts command/beat this cycle
//   bmem_raddr/rdata/rvalid - returning read beat with its address tag
//   raddr_err            - sticky read-address mismatch flag
//
// Build option:
//   MUTATIVE_CLA_RADDR_CHECK_EN - when defined, read beats whose tag does
//   not match the requested line are dropped and raddr_err is set. When
//   undefined, bmem_raddr is ignored and raddr_err is tied low.
//
// Every output comes straight from a flop, so nothing on dfp_* reaches
// bmem_* combinationally.
module mutative_cacheline_adapter
  import mutative_types::*;
#(
  parameter int BEAT_W    = CLA_BEAT_W,
  parameter int BURST_LEN = CLA_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 dfp_addr,
  input  logic                        dfp_read,
  input  logic                        dfp_write,
  input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata,
  output logic                        dfp_resp,
  output logic [31:0]                 bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [31:0]                 bmem_raddr,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic                        raddr_err
);

  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  cla_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                resp_q, resp_d;
  logic [31:0]         addr_q, addr_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [BEAT_W-1:0]   wdata_q, wdata_d;
  logic                raddr_match;

`ifdef MUTATIVE_CLA_RADDR_CHECK_EN
  logic raddr_err_q, raddr_err_d;

  assign raddr_match = (bmem_raddr == addr_q);
  // Sticky until reset: any mis-tagged beat while gathering a line.
  assign raddr_err_d = raddr_err_q |
                       ((state_q == RD_WAIT) && bmem_rvalid && !raddr_match);

  always_ff @(posedge clk) begin
    if (rst) raddr_err_q <= 1'b0;
    else     raddr_err_q <= raddr_err_d;
  end

  assign raddr_err = raddr_err_q;
`else
  logic unused_raddr;

  assign raddr_match  = 1'b1;
  assign unused_raddr = ^bmem_raddr;
  assign raddr_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        // Write has priority so a dirty victim is never lost.
        if (dfp_write) begin
          line_d  = dfp_wdata;
          addr_d  = cla_line_align(dfp_addr);
          cnt_d   = '0;
          write_d = 1'b1;
          wdata_d = dfp_wdata[BEAT_W-1:0];
          state_d = WR_BURST;
        end else if (dfp_read) begin
          addr_d  = cla_line_align(dfp_addr);
          cnt_d   = '0;
          read_d  = 1'b1;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        if (bmem_ready) begin
          read_d  = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bmem_rvalid && raddr_match) begin
          line_d[BEAT_W*int'(cnt_q) +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          // dfp_rdata only changes when a full line has been gathered.
          if (cnt_q == LAST_BEAT) begin
            rdata_d = line_d;
            resp_d  = 1'b1;
            state_d = RESP;
          end
        end
      end

      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            // Preload the next beat so bmem_wdata stays registered.
            cnt_d   = cnt_q + 1'b1;
            wdata_d = line_q[BEAT_W*int'(cnt_d) +: BEAT_W];
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // Line buffer is pure data; a partial line left by reset is never exposed.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign dfp_rdata  = rdata_q;
  assign dfp_resp   = resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = read_q;
  assign bmem_write = write_q;
  assign bmem_wdata = wdata_q;

endmodule

// File: tb/tb_mutative_cacheline_adapter.sv
// Directed testbench for mutative_cacheline_adapter.
module tb_mutative_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         raddr_err;

  int tests_run;
  int tests_failed;

  mutative_cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid), .raddr_err(raddr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0;
    dfp_wdata = '0; bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    bmem_rvalid = 1'b0;
    step(); step();
    tests_run++;
    if ({dfp_resp, bmem_read, bmem_write, raddr_err} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want 0000", {dfp_resp, bmem_read, bmem_write, raddr_err});
    end
    tests_run++;
    if (bmem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr got %h want 0", bmem_addr);
    end
    tests_run++;
    if (bmem_wdata !== 64'h0) begin
      tests_failed++; $display("FAIL reset_wdata got %h want 0", bmem_wdata);
    end
    tests_run++;
    if (dfp_rdata !== 256'h0) begin
      tests_failed++; $display("FAIL reset_rdata got %h want 0", dfp_rdata);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b0) begin
      tests_failed++; $display("FAIL idle_quiet got %b want 000", {dfp_resp, bmem_read, bmem_write});
    end
  endtask

  task automatic test_read();
    logic [63:0] b [4];
    int resp_cnt;
    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    resp_cnt = 0;
    bmem_ready = 1'b1; dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
    step();
    tests_run++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_1220) begin
      tests_failed++;
      $display("FAIL read_cmd got read=%b addr=%h want read=1 addr=00001220", bmem_read, bmem_addr);
    end
    step();
    tests_run++;
    if (bmem_read !== 1'b0) begin
      tests_failed++; $display("FAIL read_cmd_drop got %b want 0", bmem_read);
    end
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = b[i]; bmem_raddr = 32'h0000_1220;
      step();
      if (dfp_resp === 1'b1) resp_cnt++;
    end
    bmem_rvalid = 1'b0;
    tests_run++;
    if (dfp_resp !== 1'b1) begin
      tests_failed++; $display("FAIL read_resp_timing got %b want 1", dfp_resp);
    end
    tests_run++;
    if (dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      tests_failed++; $display("FAIL read_line got %h want %h", dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 1'b0;
    step();
    if (dfp_resp === 1'b1) resp_cnt++;
    tests_run++;
    if (resp_cnt != 1) begin
      tests_failed++; $display("FAIL read_resp_count got %0d want 1", resp_cnt);
    end
    tests_run++;
    if (dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      tests_failed++; $display("FAIL read_line_hold got %h want %h", dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
  endtask

  task automatic test_write_stall();
    logic [63:0] b [4];
    int acc;
    int cyc;
    b[0] = 64'hDEAD_0000_CAFE_0000; b[1] = 64'hDEAD_0001_CAFE_1111;
    b[2] = 64'hDEAD_0002_CAFE_2222; b[3] = 64'hDEAD_0003_CAFE_3333;
    acc = 0; cyc = 0;
    dfp_addr = 32'h8000_0040; dfp_wdata = {b[3], b[2], b[1], b[0]};
    dfp_write = 1'b1; bmem_ready = 1'b1;
    step();
    while (acc < 4 && cyc < 40) begin
      bmem_ready = (cyc % 2 == 0);
      tests_run++;
      if (bmem_write !== 1'b1 || bmem_wdata !== b[acc] || bmem_addr !== 32'h8000_0040 ||
          bmem_read !== 1'b0 || dfp_resp !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_beat%0d got wr=%b rd=%b resp=%b data=%h addr=%h want wr=1 rd=0 resp=0 data=%h addr=80000040",
                 acc, bmem_write, bmem_read, dfp_resp, bmem_wdata, bmem_addr, b[acc]);
      end
      if (bmem_ready) acc++;
      step();
      cyc++;
    end
    tests_run++;
    if (acc != 4) begin
      tests_failed++; $display("FAIL write_accept_count got %0d want 4", acc);
    end
    tests_run++;
    if (dfp_resp !== 1'b1 || bmem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_resp got resp=%b wr=%b want resp=1 wr=0", dfp_resp, bmem_write);
    end
    dfp_write = 1'b0; bmem_ready = 1'b1;
    step();
    tests_run++;
    if (dfp_resp !== 1'b0) begin
      tests_failed++; $display("FAIL write_resp_single got %b want 0", dfp_resp);
    end
  endtask

  task automatic test_both_requests();
    logic [63:0] b [4];
    b[0] = 64'h0123_4567_89AB_CDEF; b[1] = 64'hFEDC_BA98_7654_3210;
    b[2] = 64'hA5A5_A5A5_5A5A_5A5A; b[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    dfp_addr = 32'h0000_0A5F; dfp_wdata = {b[3], b[2], b[1], b[0]};
    dfp_read = 1'b1; dfp_write = 1'b1; bmem_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_wdata !== b[i] ||
          bmem_addr !== 32'h0000_0A40) begin
        tests_failed++;
        $display("FAIL both_beat%0d got wr=%b rd=%b data=%h addr=%h want wr=1 rd=0 data=%h addr=00000a40",
                 i, bmem_write, bmem_read, bmem_wdata, bmem_addr, b[i]);
      end
      step();
    end
    tests_run++;
    if (dfp_resp !== 1'b1 || bmem_read !== 1'b0) begin
      tests_failed++; $display("FAIL both_resp got resp=%b rd=%b want resp=1 rd=0", dfp_resp, bmem_read);
    end
    dfp_read = 1'b0; dfp_write = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] b [4];
    int resp_cnt;
    b[0] = 64'hAAAA_0000_0000_0001; b[1] = 64'hAAAA_0000_0000_0002;
    b[2] = 64'hAAAA_0000_0000_0003; b[3] = 64'hAAAA_0000_0000_0004;
    resp_cnt = 0;
    bmem_ready = 1'b1; dfp_addr = 32'h0000_2008; dfp_read = 1'b1;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = b[i]; bmem_raddr = 32'h0000_2000;
      step();
    end
    rst = 1'b1; dfp_read = 1'b0; bmem_rdata = b[2];
    step();
    tests_run++;
    if ({dfp_resp, bmem_read, bmem_write, raddr_err} !== 4'b0 || bmem_addr !== 32'h0 ||
        bmem_wdata !== 64'h0 || dfp_rdata !== 256'h0) begin
      tests_failed++;
      $display("FAIL midrst_outputs got ctrl=%b addr=%h wdata=%h rdata=%h want all 0",
               {dfp_resp, bmem_read, bmem_write, raddr_err}, bmem_addr, bmem_wdata, dfp_rdata);
    end
    rst = 1'b0;
    for (int i = 2; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = b[i];
      step();
      if (dfp_resp === 1'b1 || bmem_read === 1'b1) resp_cnt++;
    end
    bmem_rvalid = 1'b0;
    step();
    if (dfp_resp === 1'b1 || bmem_read === 1'b1) resp_cnt++;
    tests_run++;
    if (resp_cnt != 0) begin
      tests_failed++; $display("FAIL midrst_late_beats got %0d activity cycles want 0", resp_cnt);
    end
    b[0] = 64'hBBBB_0000_0000_0010; b[1] = 64'hBBBB_0000_0000_0020;
    b[2] = 64'hBBBB_0000_0000_0030; b[3] = 64'hBBBB_0000_0000_0040;
    dfp_addr = 32'h0000_3000; dfp_read = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = b[i]; bmem_raddr = 32'h0000_3000;
      step();
    end
    bmem_rvalid = 1'b0;
    tests_run++;
    if (dfp_resp !== 1'b1 || dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      tests_failed++;
      $display("FAIL midrst_new_read got resp=%b line=%h want resp=1 line=%h",
               dfp_resp, dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 1'b0;
    step();
  endtask

  task automatic test_raddr_check();
    logic [63:0] d [5];
    logic [31:0] a [5];
    logic [255:0] exp_line;
    logic [255:0] got_line;
    logic exp_err;
    int resp_cnt;
    d[0] = 64'h0A0A_0A0A_0A0A_0A0A; a[0] = 32'h0000_4000;
    d[1] = 64'hBADB_ADBA_DBAD_BADB; a[1] = 32'hFFFF_FFE0;
    d[2] = 64'h0B0B_0B0B_0B0B_0B0B; a[2] = 32'h0000_4000;
    d[3] = 64'h0C0C_0C0C_0C0C_0C0C; a[3] = 32'h0000_4000;
    d[4] = 64'h0D0D_0D0D_0D0D_0D0D; a[4] = 32'h0000_4000;
`ifdef MUTATIVE_CLA_RADDR_CHECK_EN
    exp_line = {d[4], d[3], d[2], d[0]};
    exp_err  = 1'b1;
`else
    exp_line = {d[3], d[2], d[1], d[0]};
    exp_err  = 1'b0;
`endif
    resp_cnt = 0; got_line = '0;
    bmem_ready = 1'b1; dfp_addr = 32'h0000_4010; dfp_read = 1'b1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = d[i]; bmem_raddr = a[i];
      step();
      if (dfp_resp === 1'b1) begin
        resp_cnt++; got_line = dfp_rdata; dfp_read = 1'b0;
      end
    end
    bmem_rvalid = 1'b0;
    step();
    if (dfp_resp === 1'b1) resp_cnt++;
    tests_run++;
    if (resp_cnt != 1 || got_line !== exp_line) begin
      tests_failed++;
      $display("FAIL raddr_line got resps=%0d line=%h want resps=1 line=%h", resp_cnt, got_line, exp_line);
    end
    tests_run++;
    if (raddr_err !== exp_err) begin
      tests_failed++; $display("FAIL raddr_err got %b want %b", raddr_err, exp_err);
    end
    dfp_read = 1'b0;
    step(); step();
    tests_run++;
    if (raddr_err !== exp_err) begin
      tests_failed++; $display("FAIL raddr_err_sticky got %b want %b", raddr_err, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b [4];
    int rd_cycles;
    b[0] = 64'h5555_0000_0000_0000; b[1] = 64'h5555_1111_0000_0000;
    b[2] = 64'h5555_2222_0000_0000; b[3] = 64'h5555_3333_0000_0000;
    rd_cycles = 0;
    bmem_ready = 1'b0; dfp_addr = 32'h0000_5010; dfp_read = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      if (bmem_read === 1'b1) rd_cycles++;
      tests_run++;
      if (bmem_addr !== 32'h0000_5000) begin
        tests_failed++; $display("FAIL b2b_stall_addr got %h want 00005000", bmem_addr);
      end
      step();
    end
    bmem_ready = 1'b1;
    if (bmem_read === 1'b1) rd_cycles++;
    step();
    for (int i = 0; i < 4; i++) begin
      if (bmem_read === 1'b1) rd_cycles++;
      bmem_rvalid = 1'b1; bmem_rdata = b[i]; bmem_raddr = 32'h0000_5000;
      step();
    end
    bmem_rvalid = 1'b0;
    tests_run++;
    if (rd_cycles != 3 || dfp_resp !== 1'b1 || dfp_rdata !== {b[3], b[2], b[1], b[0]}) begin
      tests_failed++;
      $display("FAIL b2b_read got rd_cycles=%0d resp=%b line=%h want 3 1 %h",
               rd_cycles, dfp_resp, dfp_rdata, {b[3], b[2], b[1], b[0]});
    end
    dfp_read = 1'b0;
    step();
    dfp_addr = 32'h0000_6000; dfp_wdata = {b[0], b[1], b[2], b[3]}; dfp_write = 1'b1;
    tests_run++;
    if (bmem_read !== 1'b0 || dfp_resp !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_gap got rd=%b resp=%b want 0 0", bmem_read, dfp_resp);
    end
    step();
    tests_run++;
    if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== 32'h0000_6000 || bmem_wdata !== b[3]) begin
      tests_failed++;
      $display("FAIL b2b_write_start got wr=%b rd=%b addr=%h data=%h want 1 0 00006000 %h",
               bmem_write, bmem_read, bmem_addr, bmem_wdata, b[3]);
    end
    step(); step(); step(); step();
    tests_run++;
    if (dfp_resp !== 1'b1 || bmem_write !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_write_resp got resp=%b wr=%b want 1 0", dfp_resp, bmem_write);
    end
    dfp_write = 1'b0;
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_read();
    test_write_stall();
    test_both_requests();
    test_reset_mid_read();
    test_raddr_check();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
